// File: rtl/sin_approx_pkg.sv
// Shared constants, widths and types for the polynomial sine generator.
// Coefficients are Q2.14 minimax terms of an odd 5th-order sine fit.
package sin_approx_pkg;

  localparam int PHASE_W = 16;
  localparam int OUT_W   = 16;
  localparam int FRAC    = 14;
  localparam int PROD_W  = 40;

  localparam logic signed [15:0] C1 = 16'sd25733;
  localparam logic signed [15:0] C3 = -16'sd10539;
  localparam logic signed [15:0] C5 = 16'sd1191;

  typedef logic [PHASE_W-1:0]        phase_t;
  typedef logic signed [OUT_W-1:0]   sample_t;

  // Round half-up, then drop FRAC fractional bits.
  function automatic logic signed [PROD_W-1:0] rnd_frac(input logic signed [PROD_W-1:0] p);
    return (p + (PROD_W'(1) <<< (FRAC - 1))) >>> FRAC;
  endfunction

endpackage

// File: rtl/sin_poly_eval.sv
// Combinational Horner evaluation of the odd sine polynomial on a folded
// first-quadrant phase; returns the saturated Q1.15 magnitude.
module sin_poly_eval
  import sin_approx_pkg::*;
(
  input  logic [14:0] u_i,
  output logic [15:0] mag_o
);

  localparam logic signed [PROD_W-1:0] C1_X = PROD_W'(C1);
  localparam logic signed [PROD_W-1:0] C3_X = PROD_W'(C3);
  localparam logic signed [PROD_W-1:0] C5_X = PROD_W'(C5);
  localparam logic signed [PROD_W-1:0] MAX_MAG = PROD_W'(32767);

  logic signed [PROD_W-1:0] u_s;
  logic signed [PROD_W-1:0] u2;
  logic signed [PROD_W-1:0] t1;
  logic signed [PROD_W-1:0] t2;
  logic signed [PROD_W-1:0] y;
  logic signed [PROD_W-1:0] y_q15;

  always_comb begin
    u_s   = $signed({{(PROD_W-15){1'b0}}, u_i});
    u2    = rnd_frac(u_s * u_s);
    t1    = rnd_frac(C5_X * u2) + C3_X;
    t2    = rnd_frac(t1 * u2) + C1_X;
    y     = rnd_frac(t2 * u_s);
    y_q15 = y <<< 1;
    // Peak of the fit slightly overshoots 1.0, so clamp to the Q1.15 range.
    if (y_q15 > MAX_MAG) begin
      mag_o = 16'd32767;
    end else if (y_q15 < 0) begin
      mag_o = 16'd0;
    end else begin
      mag_o = y_q15[15:0];
    end
  end

endmodule

// File: rtl/polynomial_sin_approximation.sv
// Two-stage sine pipeline: stage 1 folds the phase into the first quadrant,
// stage 2 evaluates the polynomial and restores the sign.
module polynomial_sin_approximation
  import sin_approx_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    in_valid,
  input  phase_t  x,
  output logic    out_valid,
  output sample_t sin_x
);

  logic [14:0] u_d, u_q;
  logic        neg_d, neg_q;
  logic        vld_q;
  sample_t     sin_d, sin_q;
  logic        out_vld_q;
  logic [15:0] mag;

  // Quadrants 1 and 3 run backwards, so mirror the fraction about pi/2.
  always_comb begin
    neg_d = x[15];
    if (x[14]) begin
      u_d = 15'd16384 - {1'b0, x[13:0]};
    end else begin
      u_d = {1'b0, x[13:0]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      u_q   <= '0;
      neg_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        u_q   <= u_d;
        neg_q <= neg_d;
      end
    end
  end

  sin_poly_eval u_poly (
    .u_i   (u_q),
    .mag_o (mag)
  );

  always_comb begin
    sin_d = neg_q ? -$signed(mag) : $signed(mag);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sin_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= vld_q;
      if (vld_q) begin
        sin_q <= sin_d;
      end
    end
  end

  assign sin_x     = sin_q;
  assign out_valid = out_vld_q;

endmodule

// File: tb/tb_polynomial_sin_approximation.sv
// Directed + randomized bench for the sine pipeline, checked against a
// plain-arithmetic model of the fold/polynomial rules and a real-valued sine.
module tb_polynomial_sin_approximation;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic [15:0]        x = '0;
  logic               out_valid;
  logic signed [15:0] sin_x;

  int tests = 0;
  int fails = 0;
  bit prev_v = 1'b0;
  int prev_x = 0;
  int hold = 0;
  int res [0:65535];

  polynomial_sin_approximation dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (out_valid),
    .sin_x     (sin_x)
  );

  always #5 clock = ~clock;

  function automatic int rnd(input longint p);
    return int'((p + 64'sd8192) >>> 14);
  endfunction

  function automatic int model(input int ph);
    int u, u2, t1, t2, y, m;
    bit neg;
    if (ph < 16384)      u = ph;
    else if (ph < 32768) u = 32768 - ph;
    else if (ph < 49152) u = ph - 32768;
    else                 u = 65536 - ph;
    neg = (ph >= 32768);
    u2 = rnd(longint'(u) * u);
    t1 = rnd(longint'(1191) * u2) - 10539;
    t2 = rnd(longint'(t1) * u2) + 25733;
    y  = rnd(longint'(t2) * u);
    m  = 2 * y;
    if (m > 32767) m = 32767;
    if (m < 0)     m = 0;
    return neg ? -m : m;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one input, advance one cycle, check the output of the previous input.
  task automatic step(input bit v, input int xv, input string tag, output int got);
    in_valid = v;
    x = 16'(xv);
    @(posedge clock);
    @(negedge clock);
    if (prev_v) hold = model(prev_x);
    check({tag, " out_valid"}, int'(out_valid), int'(prev_v));
    check({tag, " sin_x"}, int'(sin_x), hold);
    got = int'(sin_x);
    prev_v = v;
    prev_x = xv;
  endtask

  initial begin
    int got;
    int card_x [4] = '{0, 16384, 32768, 49152};
    int card_e [4] = '{0, 32767, 0, -32767};
    int mid_x  [3] = '{8192, 5461, 60075};
    int mid_e  [3] = '{23170, 16384, -16384};
    real ref_r;
    int  ref_i;

    #12;
    check("reset out_valid", int'(out_valid), 0);
    check("reset sin_x", int'(sin_x), 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(1'b1, card_x[i], "cardinal in", got);
      step(1'b0, 0, "cardinal out", got);
      check("cardinal value", got, card_e[i]);
      step(1'b0, 0, "cardinal hold", got);
    end

    for (int i = 0; i < 3; i++) begin
      step(1'b1, mid_x[i], "mid in", got);
      step(1'b0, 0, "mid out", got);
      check("mid within 16", int'(iabs(got - mid_e[i]) <= 16), 1);
    end

    step(1'b1, 1000, "gap", got);
    step(1'b0, 2000, "gap", got);
    step(1'b0, 2500, "gap", got);
    step(1'b1, 3000, "gap", got);
    step(1'b0, 0, "gap", got);
    step(1'b0, 0, "gap", got);

    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), "random", got);
    end

    step(1'b1, int'($urandom_range(0, 65535)), "pre-reset", got);
    step(1'b1, int'($urandom_range(0, 65535)), "pre-reset", got);
    #2 reset_n = 1'b0;
    #1;
    check("mid-reset out_valid", int'(out_valid), 0);
    check("mid-reset sin_x", int'(sin_x), 0);
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    prev_v = 1'b0;
    hold = 0;
    step(1'b0, 0, "post-reset", got);
    step(1'b0, 0, "post-reset", got);

    for (int k = 0; k < 65536; k++) begin
      step(1'b1, k, "sweep", got);
      if (k > 0) res[k-1] = got;
    end
    step(1'b0, 0, "sweep tail", got);
    res[65535] = got;

    for (int k = 0; k < 65536; k++) begin
      ref_r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 65536.0);
      ref_i = int'(ref_r);
      if (iabs(res[k] - ref_i) > 16) check("sweep accuracy", res[k], ref_i);
      if (res[k] == -32768) check("sweep no -32768", res[k], -32767);
      if (k < 32768 && res[k] != -res[k + 32768]) check("odd symmetry", res[k], -res[k + 32768]);
    end
    check("sweep endpoint pi", res[32768], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
